// File: rtl/token_encoder_pkg.sv
// Shared types and constants for the greedy longest-match token encoder.
// Holds the encoder and matcher state enums, the vocabulary terminator
// value and a helper that yields the reserved UNK token id for a given
// address width.
package token_encoder_pkg;

  // Encoder control states, in the order an encode walks through them.
  typedef enum logic [2:0] {
    ENC_IDLE,
    ENC_START,
    ENC_SCAN,
    ENC_WAIT,
    ENC_NEXT,
    ENC_EMIT,
    ENC_DONE
  } enc_state_t;

  // Matcher states: wait for a launch, walk one entry, report the result.
  typedef enum logic [1:0] {
    M_IDLE,
    M_CMP,
    M_FOUND,
    M_MISS
  } match_state_t;

  // Character value that closes a vocabulary entry (and, as a first
  // character, closes the whole table).
  localparam int VOCAB_TERM = 0;

  // The highest token id is reserved for "unknown"; ordinary entries never
  // reach it because every entry needs at least two vocabulary bytes.
  function automatic int unsigned unk_id(input int unsigned aw);
    return (32'd1 << aw) - 32'd1;
  endfunction

endpackage

// File: rtl/token_encoder_matcher.sv
// Entry-versus-input comparator for the token encoder.
// Walks one vocabulary entry a character per cycle starting at 'base',
// comparing it with the input starting at 'pos_init'. It always runs on to
// the entry terminator so that it can report where the next entry begins
// (npv). An entry that runs into the last vocabulary address without a
// terminator ends the table: it reports a miss with npv = 2^AW.
module token_encoder_matcher
  import token_encoder_pkg::*;
#(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  abort,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base,
  input  logic [ADDR_WIDTH:0]   pos_init,
  input  logic [ADDR_WIDTH:0]   in_len,
  input  logic [DATA_WIDTH-1:0] voc_char,
  input  logic [DATA_WIDTH-1:0] in_char,
  output logic [ADDR_WIDTH-1:0] voc_addr,
  output logic [ADDR_WIDTH-1:0] in_addr,
  output logic                  done,
  output logic                  found,
  output logic [ADDR_WIDTH:0]   len,
  output logic [ADDR_WIDTH:0]   npv
);

  localparam logic [DATA_WIDTH-1:0] TERM      = DATA_WIDTH'(VOCAB_TERM);
  localparam logic [ADDR_WIDTH:0]   ONE_W     = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH:0]   TABLE_END = {1'b1, {ADDR_WIDTH{1'b0}}};

  match_state_t          state;
  logic [ADDR_WIDTH-1:0] av;
  logic [ADDR_WIDTH:0]   pos;
  logic                  mism;

  assign voc_addr = av;
  assign in_addr  = pos[ADDR_WIDTH-1:0];

  // Comparator FSM: latch the launch point, compare until the terminator
  // (remembering any mismatch), then hold 'done' for one result cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= M_IDLE;
      av    <= '0;
      pos   <= '0;
      mism  <= 1'b0;
      done  <= 1'b0;
      found <= 1'b0;
      len   <= '0;
      npv   <= '0;
    end else if (abort) begin
      state <= M_IDLE;
      done  <= 1'b0;
    end else begin
      case (state)
        M_IDLE: begin
          done <= 1'b0;
          if (start) begin
            av    <= base;
            pos   <= pos_init;
            len   <= '0;
            mism  <= 1'b0;
            found <= 1'b0;
            state <= M_CMP;
          end
        end
        M_CMP: begin
          if (voc_char == TERM) begin
            found <= ~mism;
            npv   <= {1'b0, av} + ONE_W;
            done  <= 1'b1;
            state <= mism ? M_MISS : M_FOUND;
          end else if (av == '1) begin
            found <= 1'b0;
            npv   <= TABLE_END;
            done  <= 1'b1;
            state <= M_MISS;
          end else begin
            if (!mism && (pos < in_len) && (in_char == voc_char)) begin
              len <= len + ONE_W;
              pos <= pos + ONE_W;
            end else begin
              mism <= 1'b1;
            end
            av <= av + 1'b1;
          end
        end
        M_FOUND, M_MISS: begin
          done  <= 1'b0;
          state <= M_IDLE;
        end
        default: begin
          done  <= 1'b0;
          state <= M_IDLE;
        end
      endcase
    end
  end

endmodule

// File: rtl/token_encoder.sv
// Greedy longest-match tokenizer core.
// Converts the byte string in the input buffer into vocabulary token ids in
// the output buffer. The vocabulary is a zero-terminated string table; each
// input position tries every entry through the matcher and keeps the longest
// full match (earliest entry on ties).
// Optional feature macro: ENCODER_UNK_EN -- when defined, a position with no
// match emits the UNK id and advances one character; otherwise it raises err
// and finishes without emitting.
// Note: the port named rst_n is an active-high asynchronous reset.
module token_encoder
  import token_encoder_pkg::*;
#(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cs,
  input  logic                  in_we,
  input  logic [ADDR_WIDTH-1:0] in_addr,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [ADDR_WIDTH:0]   in_len,
  input  logic                  voc_we,
  input  logic [ADDR_WIDTH-1:0] voc_addr,
  input  logic [DATA_WIDTH-1:0] voc_data,
  input  logic [ADDR_WIDTH-1:0] out_addr,
  output logic [ADDR_WIDTH-1:0] out_data,
  output logic [ADDR_WIDTH:0]   out_count,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam int                    DEPTH  = 1 << ADDR_WIDTH;
  localparam logic [DATA_WIDTH-1:0] TERM   = DATA_WIDTH'(VOCAB_TERM);
  localparam logic [ADDR_WIDTH-1:0] UNK_ID = ADDR_WIDTH'(unk_id(ADDR_WIDTH));
  localparam logic [ADDR_WIDTH:0]   ONE_W  = (ADDR_WIDTH+1)'(1);
`ifdef ENCODER_UNK_EN
  localparam logic                  UNK_EN = 1'b1;
`else
  localparam logic                  UNK_EN = 1'b0;
`endif

  logic [DATA_WIDTH-1:0] in_mem  [DEPTH];
  logic [DATA_WIDTH-1:0] voc_mem [DEPTH];
  logic [ADDR_WIDTH-1:0] out_mem [DEPTH];

  enc_state_t            state;
  logic [ADDR_WIDTH:0]   ai;
  logic [ADDR_WIDTH-1:0] ar;
  logic [ADDR_WIDTH:0]   aw;
  logic [ADDR_WIDTH:0]   w;
  logic [ADDR_WIDTH-1:0] best_id;
  logic [ADDR_WIDTH-1:0] eid;
  logic [ADDR_WIDTH:0]   len_r;

  logic                  m_start;
  logic                  m_done;
  logic                  m_found;
  logic [ADDR_WIDTH:0]   m_len;
  logic [ADDR_WIDTH:0]   m_npv;
  logic [ADDR_WIDTH-1:0] m_voc_addr;
  logic [ADDR_WIDTH-1:0] m_in_addr;

  logic                  entry_empty;
  logic [ADDR_WIDTH:0]   emit_ai;
  logic [ADDR_WIDTH:0]   aw_next;
  logic [ADDR_WIDTH-1:0] emit_id;
  logic                  out_we;

  assign out_data  = out_mem[out_addr];
  assign out_count = aw;

  // Launch decisions and the values an EMIT step would commit.
  always_comb begin
    entry_empty = (voc_mem[ar] == TERM);
    m_start     = (state == ENC_SCAN) && !entry_empty;
    emit_ai     = (w != '0) ? (ai + w) : (ai + ONE_W);
    aw_next     = aw + ONE_W;
    emit_id     = (w != '0) ? best_id : UNK_ID;
    out_we      = cs && (state == ENC_EMIT) && ((w != '0) || UNK_EN);
  end

  // Host write ports are locked out while an encode runs; the encoder
  // itself is the only writer of the output buffer.
  always_ff @(posedge clk) begin
    if (in_we && !busy) begin
      in_mem[in_addr] <= in_data;
    end
    if (voc_we && !busy) begin
      voc_mem[voc_addr] <= voc_data;
    end
    if (out_we) begin
      out_mem[aw[ADDR_WIDTH-1:0]] <= emit_id;
    end
  end

  token_encoder_matcher #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_matcher (
    .clk      (clk),
    .rst      (rst_n),
    .abort    (~cs),
    .start    (m_start),
    .base     (ar),
    .pos_init (ai),
    .in_len   (len_r),
    .voc_char (voc_mem[m_voc_addr]),
    .in_char  (in_mem[m_in_addr]),
    .voc_addr (m_voc_addr),
    .in_addr  (m_in_addr),
    .done     (m_done),
    .found    (m_found),
    .len      (m_len),
    .npv      (m_npv)
  );

  // Encoder FSM: for each input position sweep the whole table, keep the
  // longest match, emit it, and move on until the input or output runs out.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state   <= ENC_IDLE;
      ai      <= '0;
      ar      <= '0;
      aw      <= '0;
      w       <= '0;
      best_id <= '0;
      eid     <= '0;
      len_r   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else if (!cs) begin
      state <= ENC_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        ENC_IDLE: begin
          state <= ENC_START;
          busy  <= 1'b1;
          done  <= 1'b0;
        end
        ENC_START: begin
          ai      <= '0;
          ar      <= '0;
          aw      <= '0;
          w       <= '0;
          best_id <= '0;
          eid     <= '0;
          err     <= 1'b0;
          len_r   <= in_len;
          if (in_len == '0) begin
            state <= ENC_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            state <= ENC_SCAN;
          end
        end
        ENC_SCAN: begin
          state <= entry_empty ? ENC_EMIT : ENC_WAIT;
        end
        ENC_WAIT: begin
          if (m_done) begin
            state <= ENC_NEXT;
          end
        end
        ENC_NEXT: begin
          if (m_found && (m_len > w)) begin
            w       <= m_len;
            best_id <= eid;
          end
          eid   <= eid + 1'b1;
          ar    <= m_npv[ADDR_WIDTH-1:0];
          state <= m_npv[ADDR_WIDTH] ? ENC_EMIT : ENC_SCAN;
        end
        ENC_EMIT: begin
          if ((w == '0) && !UNK_EN) begin
            err   <= 1'b1;
            state <= ENC_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            ai <= emit_ai;
            aw <= aw_next;
            if (emit_ai >= len_r) begin
              state <= ENC_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else if (aw_next[ADDR_WIDTH]) begin
              err   <= 1'b1;
              state <= ENC_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              ar    <= '0;
              eid   <= '0;
              w     <= '0;
              state <= ENC_SCAN;
            end
          end
        end
        ENC_DONE: begin
          state <= ENC_DONE;
        end
        default: begin
          state <= ENC_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_token_encoder.sv
// Self-checking bench for token_encoder. A greedy longest-match model works
// directly on byte arrays; a compare process checks every cycle that done is
// high while an encode is being observed.
module tb_token_encoder;

  logic       clk;
  logic       rst_n;
  logic       cs;
  logic       in_we;
  logic [3:0] in_addr;
  logic [7:0] in_data;
  logic [4:0] in_len;
  logic       voc_we;
  logic [3:0] voc_addr;
  logic [7:0] voc_data;
  logic [3:0] out_addr;
  logic [3:0] out_data;
  logic [4:0] out_count;
  logic       busy;
  logic       done;
  logic       err;

  int         checks = 0;
  int         errors = 0;
  bit         chk_en = 0;
  int         last_cycles = 0;

  logic [7:0] voc_m [16];
  logic [7:0] in_m  [16];
  int         len_m;
  int         exp_tok [$];
  int         exp_cnt;
  int         exp_err;

  token_encoder #(.ADDR_WIDTH(4), .DATA_WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cs        (cs),
    .in_we     (in_we),
    .in_addr   (in_addr),
    .in_data   (in_data),
    .in_len    (in_len),
    .voc_we    (voc_we),
    .voc_addr  (voc_addr),
    .voc_data  (voc_data),
    .out_addr  (out_addr),
    .out_data  (out_data),
    .out_count (out_count),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic check_output(input string name, input int actual, input int required);
    checks++;
    if (actual != required) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, required);
    end
  endtask

  // Greedy longest-match reference: parse the table, then tokenize.
  task automatic run_model();
    int st [$];
    int ln [$];
    int pos, t, ai, bw, best;
    bit ok;
    pos = 0;
    while (pos < 16 && voc_m[pos] != 8'h00) begin
      t = pos;
      while (t < 16 && voc_m[t] != 8'h00) t++;
      if (t == 16) break;
      st.push_back(pos);
      ln.push_back(t - pos);
      pos = t + 1;
    end
    exp_tok.delete();
    exp_err = 0;
    ai = 0;
    while (ai < len_m) begin
      bw = 0;
      best = 0;
      for (int e = 0; e < st.size(); e++) begin
        if (ai + ln[e] <= len_m && ln[e] > bw) begin
          ok = 1;
          for (int k = 0; k < ln[e]; k++)
            if (in_m[ai+k] != voc_m[st[e]+k]) ok = 0;
          if (ok) begin
            bw = ln[e];
            best = e;
          end
        end
      end
      if (bw > 0) begin
        exp_tok.push_back(best);
        ai += bw;
      end else begin
`ifdef ENCODER_UNK_EN
        exp_tok.push_back(15);
        ai += 1;
`else
        exp_err = 1;
        break;
`endif
      end
      if (ai < len_m && exp_tok.size() == 16) begin
        exp_err = 1;
        break;
      end
    end
    exp_cnt = exp_tok.size();
  endtask

  // Compute expectations and load both memories from the model arrays.
  task automatic prepare();
    run_model();
    for (int i = 0; i < 16; i++) begin
      voc_we = 1'b1; voc_addr = 4'(i); voc_data = voc_m[i];
      in_we  = 1'b1; in_addr  = 4'(i); in_data  = in_m[i];
      @(negedge clk);
    end
    voc_we = 1'b0;
    in_we  = 1'b0;
    in_len = 5'(len_m);
  endtask

  // '.' in the vocabulary string stands for the zero terminator.
  task automatic apply_stimulus(input string vs, input string is);
    for (int i = 0; i < 16; i++) begin
      voc_m[i] = 8'h00;
      if (i < vs.len()) voc_m[i] = (vs[i] == 8'h2E) ? 8'h00 : vs[i];
      in_m[i] = (i < is.len()) ? is[i] : 8'h00;
    end
    len_m = is.len();
    prepare();
  endtask

  task automatic run_encode(input bit poke);
    int cycles;
    chk_en = 1;
    cs = 1'b1;
    cycles = 0;
    while (!done && cycles < 5000) begin
      @(negedge clk);
      cycles++;
      if (poke && cycles == 3) begin
        check_output("busy_during_encode", busy, 1);
        voc_we = 1'b1; voc_addr = 4'd0; voc_data = 8'h7A;
        in_we  = 1'b1; in_addr  = 4'd0; in_data  = 8'h7A;
        @(negedge clk);
        cycles++;
        voc_we = 1'b0;
        in_we  = 1'b0;
      end
    end
    last_cycles = cycles;
    check_output("done_reached", done, 1);
    for (int a = 0; a < 16; a++) begin
      out_addr = 4'(a);
      @(negedge clk);
    end
    chk_en = 0;
    cs = 1'b0;
    @(negedge clk);
    check_output("idle_done", done, 0);
    check_output("idle_busy", busy, 0);
  endtask

  // Every cycle the finished result is visible, hold the DUT to the model.
  always @(negedge clk) begin
    if (chk_en && done) begin
      check_output("busy_when_done", busy, 0);
      check_output("out_count", out_count, exp_cnt);
      check_output("err", err, exp_err);
      if (out_addr < exp_cnt)
        check_output("token", out_data, exp_tok[out_addr]);
    end
  end

  initial begin
    int n, l, pos;
    rst_n = 1'b1; cs = 1'b0;
    in_we = 1'b0; in_addr = '0; in_data = '0; in_len = '0;
    voc_we = 1'b0; voc_addr = '0; voc_data = '0; out_addr = '0;
    repeat (3) @(negedge clk);
    check_output("reset_busy", busy, 0);
    check_output("reset_done", done, 0);
    check_output("reset_err", err, 0);
    check_output("reset_count", out_count, 0);
    rst_n = 1'b0;
    @(negedge clk);

    apply_stimulus("a.ab.b..", "abb");
    check_output("model_abb_cnt", exp_cnt, 2);
    check_output("model_abb_t0", exp_tok[0], 1);
    check_output("model_abb_t1", exp_tok[1], 2);
    run_encode(0);
    check_output("abb_count_lit", out_count, 2);

    apply_stimulus("a.ab.b..", "aab");
    check_output("model_aab_t0", exp_tok[0], 0);
    check_output("model_aab_t1", exp_tok[1], 1);
    run_encode(0);

    apply_stimulus("a.ab.b..", "c");
`ifdef ENCODER_UNK_EN
    check_output("model_c_cnt", exp_cnt, 1);
    check_output("model_c_tok", exp_tok[0], 15);
`else
    check_output("model_c_cnt", exp_cnt, 0);
    check_output("model_c_err", exp_err, 1);
`endif
    run_encode(0);

    apply_stimulus("a.ab.b..", "");
    run_encode(0);
    check_output("len0_within_2", (last_cycles <= 2) ? 1 : 0, 1);

    apply_stimulus("a.ab.b..", "abb");
    run_encode(1);

    apply_stimulus("a..", "aaaaaaaaaaaaaaaa");
    check_output("model_16a_cnt", exp_cnt, 16);
    check_output("model_16a_err", exp_err, 0);
    run_encode(0);
    check_output("16a_count_lit", out_count, 16);

    cs = 1'b1;
    repeat (5) @(negedge clk);
    check_output("abort_busy_before", busy, 1);
    cs = 1'b0;
    @(negedge clk);
    check_output("abort_busy", busy, 0);
    check_output("abort_done", done, 0);

    cs = 1'b1;
    repeat (40) @(negedge clk);
    check_output("progress_before_reset", (out_count != 0) ? 1 : 0, 1);
    #2 rst_n = 1'b1;
    #1;
    check_output("midreset_busy", busy, 0);
    check_output("midreset_done", done, 0);
    check_output("midreset_err", err, 0);
    check_output("midreset_count", out_count, 0);
    @(negedge clk);
    rst_n = 1'b0;
    cs = 1'b0;
    @(negedge clk);

    for (int it = 0; it < 40; it++) begin
      for (int i = 0; i < 16; i++) voc_m[i] = 8'h00;
      pos = 0;
      n = $urandom_range(0, 5);
      for (int e = 0; e < n; e++) begin
        l = $urandom_range(1, 3);
        if (pos + l > 15) break;
        for (int k = 0; k < l; k++) voc_m[pos+k] = 8'($urandom_range(97, 99));
        pos += l + 1;
      end
      if ($urandom_range(0, 7) == 0)
        for (int i = pos; i < 16; i++) voc_m[i] = 8'h61;
      len_m = $urandom_range(0, 16);
      for (int i = 0; i < 16; i++)
        in_m[i] = (i < len_m) ? 8'($urandom_range(97, 100)) : 8'h00;
      prepare();
      run_encode(0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/token_encoder.md
# token_encoder

Greedy longest-match tokenizer core (module `encoder`): converts a byte string held in an internal input buffer into vocabulary token ids held in an internal output buffer. The vocabulary is a zero-terminated string table in internal memory, and a `matcher` sub-unit compares one vocabulary entry at a time. It sits between a host loader and downstream token consumers.

## Interface
- ADDR_WIDTH, 4, address width of input, vocab and output memories (depth 2^ADDR_WIDTH each); token id width
- DATA_WIDTH, 8, character width
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  reset, asynchronous, active-high (1 = reset, despite the name)
- cs  in  1  chip select; high starts/holds an encode, low returns to IDLE
- in_we / in_addr / in_data  in  1/AW/DW  input-buffer write port
- in_len  in  AW+1  input length in characters, sampled at start
- voc_we / voc_addr / voc_data  in  1/AW/DW  vocab-memory write port
- out_addr  in  AW  output-buffer read address
- out_data  out  AW  token id at out_addr, combinational read
- out_count  out  AW+1  tokens written
- busy  out  1  encode in progress
- done  out  1  encode finished, held while cs high
- err  out  1  overflow or (without UNK) no-match error

## Operation
- Vocab format: entries packed back to back, each a non-zero character run terminated by 0; an entry whose first character is 0, or reaching the last vocab address, ends the table. Token id = entry ordinal (0,1,2,…). Id 2^AW-1 is reserved as UNK.
- Memory writes are accepted only when busy=0; writes while busy are ignored.
- Encoder FSM: IDLE -> (cs=1) START -> SCAN -> WAIT -> NEXT -> SCAN… -> EMIT -> SCAN or DONE.
- START: ai=0, aw=0, out_count=0, err=0; if in_len=0 go to DONE.
- SCAN: launch matcher on entry at ar (entry start) with input position ai; clear best (w=0) at first entry of each position.
- WAIT: until matcher done. matcher: IDLE -> CMP (one character per cycle; av, ai advance) -> FOUND (terminator reached, all matched) or MISS (mismatch or input end). It reports match length and npv (address after the terminator).
- NEXT: if found and length > w, set w = length and best id = entry ordinal (ties keep the earlier entry). ar = npv; if table ends, go to EMIT, else SCAN.
- EMIT: if w>0, out_mem[aw] = best id and ai += w; else UNK handling (see Configuration). aw++, out_count++. Then DONE if ai >= in_len or aw wrapped (aw = 2^AW; err=1), else reset ar=0 and SCAN.
- DONE: done=1, busy=0; cs low -> IDLE (done cleared; out_count and memories kept).
- cs low in any busy state aborts to IDLE at the next edge; partial output remains readable.

## Timing
- Reset: state IDLE, busy=0, done=0, err=0, out_count=0, ai/ar/aw/w=0; memory contents unspecified.
- matcher cost per entry: 1 launch cycle + (characters compared) cycles + 1 result cycle.
- done rises the cycle after the final EMIT; busy is high from START through EMIT.
- Reset asserted mid-encode returns immediately (asynchronously) to the reset values.

## Configuration
- ENCODER_UNK_EN defined: unmatched position emits UNK (2^AW-1), ai += 1, continue.
- Not defined: unmatched position sets err=1, goes to DONE without emitting.

## Structure
- Shared package `encoder_pkg`: state enums for encoder and matcher, UNK id constant, vocab terminator constant.
- One sub-module `matcher` (entry-vs-input comparator with found/done/length/npv outputs); memories and the encoder FSM stay in `encoder`.

## Test plan
- Vocab "a\0ab\0b\0\0", input "abb", cs=1 -> out [1,2], out_count=2, done=1, err=0.
- Same vocab, input "aab" -> out [0,1], out_count=2.
- Input "c", ENCODER_UNK_EN defined -> out [15], count 1; undefined -> count 0, err=1.
- in_len=0 -> done within 2 cycles, out_count=0.
- Vocab "a\0\0", 16 × "a", then a 17th character in a run with in_len=16 -> 16 tokens, err=0; drop cs mid-run -> IDLE, done=0, busy=0 next edge.
- Assert rst_n=1 mid-encode -> busy, done, err, out_count all 0 immediately; memory writes during busy ignored.
